// File: rtl/dflow_qdr_pkg.sv
// Shared types and constants for the dflow QDR command scheduler.
// Imported by the scheduler, its bus interface and the testbench.
package dflow_qdr_pkg;

  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_DATA_W   = 144;
  localparam int BLANK_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE,
    WR_PHASE,
    RD_PHASE
  } sched_state_e;

endpackage

// File: rtl/dflow_qdr_sched_if.sv
// Requester, QDR user-app and read-return signals of the scheduler.
// slave = scheduler side, master = store/replay paths plus the QDR controller.
interface dflow_qdr_sched_if
  import dflow_qdr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic              rd_gnt;
  logic              user_app_wr_cmd;
  logic [ADDR_W-1:0] user_app_wr_addr;
  logic [DATA_W-1:0] user_app_wr_data;
  logic              user_app_rd_cmd;
  logic [ADDR_W-1:0] user_app_rd_addr;
  logic              user_app_rd_valid;
  logic [DATA_W-1:0] user_app_rd_data;
  logic              ret_vld;
  logic [DATA_W-1:0] ret_data;
  logic              ret_ready;

  modport slave (
    input  wr_req, wr_data, rd_req, user_app_rd_valid, user_app_rd_data, ret_ready,
    output wr_gnt, rd_gnt, user_app_wr_cmd, user_app_wr_addr, user_app_wr_data,
           user_app_rd_cmd, user_app_rd_addr, ret_vld, ret_data
  );

  modport master (
    output wr_req, wr_data, rd_req, user_app_rd_valid, user_app_rd_data, ret_ready,
    input  wr_gnt, rd_gnt, user_app_wr_cmd, user_app_wr_addr, user_app_wr_data,
           user_app_rd_cmd, user_app_rd_addr, ret_vld, ret_data
  );

endinterface

// File: rtl/dflow_ret_fifo.sv
// Synchronous first-word-fall-through FIFO for QDR read returns.
// A push on a full FIFO is accepted only together with a pop.
module dflow_ret_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 144
) (
  input  logic                     qdr_clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             push_ok;
  logic             pop_ok;

  assign pop_vld  = (count != '0);
  assign pop_data = mem[rd_idx];
  assign pop_ok   = pop && pop_vld;
  assign push_ok  = push && ((count != (AW+1)'(DEPTH)) || pop_ok);

  // NOTE: storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge qdr_clk) begin
    if (push_ok) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_idx <= wr_idx + 1'b1;
      if (pop_ok)  rd_idx <= rd_idx + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/dflow_qdr_sched.sv
// Shares the QDR user-app command port between the store (write) and replay (read)
// paths with weighted round-robin, a circular address window and credit-protected returns.
module dflow_qdr_sched
  import dflow_qdr_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WR_WEIGHT = 4,
  parameter int RD_WEIGHT = 4,
  parameter int RET_DEPTH = 16
) (
  input  logic              qdr_clk,
  input  logic              resetn,
  input  logic              sw_rst,
  input  logic              init_calib_complete,
  input  logic [ADDR_W-1:0] mem_addr_low,
  input  logic [ADDR_W-1:0] mem_addr_high,
  dflow_qdr_sched_if.slave  bus,
  output logic [ADDR_W:0]   fill_count,
  output logic              wrapped,
  output logic              rd_err
);
  localparam int CW = $clog2(RET_DEPTH) + 1;
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  sched_state_e      state, state_nxt;
  logic [7:0]        burst_cnt;
  logic [ADDR_W-1:0] cfg_low, cfg_high, wr_ptr, rd_ptr;
  logic [ADDR_W:0]   win_size;
  logic [CW-1:0]     outstanding, ret_count;
  logic [BW-1:0]     blank_cnt;
  logic              core_rstn, cfg_bad, wr_elig, rd_elig, wr_gnt, rd_gnt;
  logic              wr_burst_done, rd_burst_done, wr_at_end, rd_at_end;
  logic              ret_push, rd_spurious;

  assign core_rstn = resetn && !sw_rst;
  assign cfg_bad   = (cfg_high < cfg_low);
  assign win_size  = {1'b0, cfg_high} - {1'b0, cfg_low} + (ADDR_W+1)'(1);

  // Reads stay blocked while blanking, so every return seen then is stale.
  assign wr_elig = bus.wr_req && init_calib_complete && !cfg_bad;
  assign rd_elig = bus.rd_req && init_calib_complete && !cfg_bad && (fill_count != '0)
                && (blank_cnt == '0)
                && (({1'b0, outstanding} + {1'b0, ret_count}) < (CW+1)'(RET_DEPTH));

  assign wr_gnt     = (state == WR_PHASE) && wr_elig;
  assign rd_gnt     = (state == RD_PHASE) && rd_elig;
  assign bus.wr_gnt = wr_gnt;
  assign bus.rd_gnt = rd_gnt;

  assign wr_burst_done = ({1'b0, burst_cnt} + 9'(wr_gnt)) >= 9'(WR_WEIGHT);
  assign rd_burst_done = ({1'b0, burst_cnt} + 9'(rd_gnt)) >= 9'(RD_WEIGHT);

  assign wr_at_end = (wr_ptr == cfg_high);
  assign rd_at_end = (rd_ptr == cfg_high)
                  || ({1'b0, rd_ptr} == {1'b0, cfg_low} + fill_count - (ADDR_W+1)'(1));

  assign ret_push    = bus.user_app_rd_valid && (blank_cnt == '0) && (outstanding != '0);
  assign rd_spurious = bus.user_app_rd_valid && (blank_cnt == '0) && (outstanding == '0);

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (wr_elig)      state_nxt = WR_PHASE;
        else if (rd_elig) state_nxt = RD_PHASE;
      end
      WR_PHASE: begin
        if (rd_elig && (!wr_elig || wr_burst_done)) state_nxt = RD_PHASE;
        else if (!wr_elig && !rd_elig)              state_nxt = IDLE;
      end
      RD_PHASE: begin
        if (wr_elig && (!rd_elig || rd_burst_done)) state_nxt = WR_PHASE;
        else if (!wr_elig && !rd_elig)              state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!init_calib_complete) state_nxt = IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge qdr_clk) begin
    if (!core_rstn) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                        burst_cnt <= '0;
      else if ((wr_gnt || rd_gnt) && burst_cnt != '1) burst_cnt <= burst_cnt + 8'd1;
    end
  end

  // The window bounds follow the inputs for as long as the block is held in reset.
  always_ff @(posedge qdr_clk) begin
    if (!core_rstn) begin
      cfg_low  <= mem_addr_low;
      cfg_high <= mem_addr_high;
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (!core_rstn) begin
      bus.user_app_wr_cmd  <= 1'b0;
      bus.user_app_wr_addr <= '0;
      bus.user_app_wr_data <= '0;
      bus.user_app_rd_cmd  <= 1'b0;
      bus.user_app_rd_addr <= '0;
      wr_ptr      <= mem_addr_low;
      rd_ptr      <= mem_addr_low;
      fill_count  <= '0;
      wrapped     <= 1'b0;
      rd_err      <= 1'b0;
      outstanding <= '0;
      blank_cnt   <= BW'(BLANK_CYCLES);
    end else begin
      bus.user_app_wr_cmd <= wr_gnt;
      bus.user_app_rd_cmd <= rd_gnt;
      if (wr_gnt) begin
        bus.user_app_wr_addr <= wr_ptr;
        bus.user_app_wr_data <= bus.wr_data;
        wr_ptr <= wr_at_end ? cfg_low : wr_ptr + 1'b1;
        if (wr_at_end)              wrapped    <= 1'b1;
        if (fill_count != win_size) fill_count <= fill_count + 1'b1;
      end
      if (rd_gnt) begin
        bus.user_app_rd_addr <= rd_ptr;
        rd_ptr <= rd_at_end ? cfg_low : rd_ptr + 1'b1;
      end
      outstanding <= outstanding + CW'(rd_gnt) - CW'(ret_push);
      if (rd_spurious)       rd_err    <= 1'b1;
      if (blank_cnt != '0)   blank_cnt <= blank_cnt - 1'b1;
    end
  end

  dflow_ret_fifo #(
    .DEPTH (RET_DEPTH),
    .WIDTH (DATA_W)
  ) u_ret_fifo (
    .qdr_clk   (qdr_clk),
    .resetn    (core_rstn),
    .push      (ret_push),
    .push_data (bus.user_app_rd_data),
    .pop       (bus.ret_ready),
    .pop_vld   (bus.ret_vld),
    .pop_data  (bus.ret_data),
    .count     (ret_count)
  );

endmodule

// File: tb/tb_dflow_qdr_sched.sv
// Directed bench for dflow_qdr_sched with a latency-10 QDR memory model.
// Expected addresses, grant patterns and return data are written out by hand.
module tb_dflow_qdr_sched;
  import dflow_qdr_pkg::*;

  localparam int AW  = 19;
  localparam int DW  = 144;
  localparam int LAT = 10;

  logic          qdr_clk = 1'b0;
  logic          resetn  = 1'b0;
  logic          sw_rst  = 1'b0;
  logic          calib   = 1'b0;
  logic [AW-1:0] lo      = '0;
  logic [AW-1:0] hi      = '0;
  logic          inj     = 1'b0;
  logic [AW:0]   fill_count;
  logic          wrapped, rd_err;

  int checks = 0;
  int errors = 0;

  dflow_qdr_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dflow_qdr_sched #(
    .ADDR_W(AW), .DATA_W(DW), .WR_WEIGHT(4), .RD_WEIGHT(4), .RET_DEPTH(16)
  ) dut (
    .qdr_clk             (qdr_clk),
    .resetn              (resetn),
    .sw_rst              (sw_rst),
    .init_calib_complete (calib),
    .mem_addr_low        (lo),
    .mem_addr_high       (hi),
    .bus                 (bus),
    .fill_count          (fill_count),
    .wrapped             (wrapped),
    .rd_err              (rd_err)
  );

  always #5 qdr_clk = ~qdr_clk;

  // Monitors and QDR model run on the falling edge, away from DUT updates.
  logic [DW-1:0] mem [64];
  bit            pv [LAT] = '{default: 1'b0};
  logic [DW-1:0] pd [LAT];
  logic [AW-1:0] wr_addr_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [DW-1:0] ret_q[$];
  bit            gnt_q[$];
  int            both_cnt = 0;

  always @(negedge qdr_clk) begin
    if (bus.user_app_wr_cmd) begin
      wr_addr_q.push_back(bus.user_app_wr_addr);
      mem[bus.user_app_wr_addr[5:0]] = bus.user_app_wr_data;
    end
    if (bus.user_app_rd_cmd) rd_addr_q.push_back(bus.user_app_rd_addr);
    if (bus.ret_vld && bus.ret_ready) ret_q.push_back(bus.ret_data);
    if (bus.wr_gnt && bus.rd_gnt) both_cnt++;
    if (bus.wr_gnt && bus.wr_req)      gnt_q.push_back(1'b1);
    else if (bus.rd_gnt && bus.rd_req) gnt_q.push_back(1'b0);
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = bus.user_app_rd_cmd;
    pd[0] = mem[bus.user_app_rd_addr[5:0]];
    bus.user_app_rd_valid = pv[LAT-1] | inj;
    bus.user_app_rd_data  = pd[LAT-1];
  end

  function automatic logic [DW-1:0] dpat(input int k);
    logic [17:0] w;
    w = 18'(k) ^ 18'h2A5A5;
    return {8{w}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge qdr_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic [AW-1:0] l, input logic [AW-1:0] h);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    resetn = 1'b0;
    lo = l;
    hi = h;
    ticks(3);
    resetn = 1'b1;
    ticks(BLANK_CYCLES + 6);
    wr_addr_q.delete();
    rd_addr_q.delete();
    ret_q.delete();
    gnt_q.delete();
    both_cnt = 0;
  endtask

  task automatic write_n(input int n);
    int k = 0;
    int g = 0;
    bus.wr_req = 1'b1;
    while (k < n && g < 100) begin
      bus.wr_data = dpat(k);
      #1;
      if (bus.wr_gnt) k++;
      tick();
      g++;
    end
    bus.wr_req = 1'b0;
    check("write_count", k, n);
  endtask

  initial begin
    int g;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    bus.wr_data = dpat(7);
    bus.ret_ready = 1'b1;
    calib = 1'b1;
    lo = 19'h10;
    hi = 19'h13;

    // Reset state with requests present.
    ticks(3);
    check("rst_wr_gnt", bus.wr_gnt, 0);
    check("rst_rd_gnt", bus.rd_gnt, 0);
    check("rst_wr_cmd", bus.user_app_wr_cmd, 0);
    check("rst_wr_addr", bus.user_app_wr_addr, 0);
    check("rst_wr_data", bus.user_app_wr_data, 0);
    check("rst_rd_cmd", bus.user_app_rd_cmd, 0);
    check("rst_rd_addr", bus.user_app_rd_addr, 0);
    check("rst_ret_vld", bus.ret_vld, 0);
    check("rst_fill", fill_count, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_rd_err", rd_err, 0);

    // Six writes into a four-word window wrap around.
    do_reset(19'h10, 19'h13);
    write_n(6);
    ticks(2);
    check("t1_wr_count", wr_addr_q.size(), 6);
    if (wr_addr_q.size() == 6) begin
      check("t1_addr0", wr_addr_q[0], 19'h10);
      check("t1_addr1", wr_addr_q[1], 19'h11);
      check("t1_addr2", wr_addr_q[2], 19'h12);
      check("t1_addr3", wr_addr_q[3], 19'h13);
      check("t1_addr4", wr_addr_q[4], 19'h10);
      check("t1_addr5", wr_addr_q[5], 19'h11);
    end
    check("t1_wrapped", wrapped, 1);
    check("t1_fill", fill_count, 4);

    // Three words stored, replay loops over them.
    do_reset(19'h10, 19'h13);
    write_n(3);
    ticks(2);
    bus.rd_req = 1'b1;
    g = 0;
    while (rd_addr_q.size() < 7 && g < 200) begin tick(); g++; end
    bus.rd_req = 1'b0;
    ticks(25);
    check("t2_rd_count_ok", rd_addr_q.size() >= 7, 1);
    if (rd_addr_q.size() >= 7) begin
      check("t2_addr0", rd_addr_q[0], 19'h10);
      check("t2_addr1", rd_addr_q[1], 19'h11);
      check("t2_addr2", rd_addr_q[2], 19'h12);
      check("t2_addr3", rd_addr_q[3], 19'h10);
      check("t2_addr4", rd_addr_q[4], 19'h11);
      check("t2_addr5", rd_addr_q[5], 19'h12);
      check("t2_addr6", rd_addr_q[6], 19'h10);
    end
    check("t2_fill", fill_count, 3);
    check("t2_ret_count", ret_q.size(), rd_addr_q.size());
    for (int i = 0; i < ret_q.size() && i < 7; i++) check("t2_ret_data", ret_q[i], dpat(i % 3));

    // Both requesters busy: 4 writes, 4 reads, repeating.
    do_reset(19'h10, 19'h13);
    bus.wr_data = dpat(1);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    ticks(40);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    ticks(25);
    check("t3_gnt_count_ok", gnt_q.size() >= 16, 1);
    for (int i = 0; i < 16 && i < gnt_q.size(); i++)
      check($sformatf("t3_gnt%0d", i), gnt_q[i], ((i / 4) % 2) == 0);
    check("t3_never_both", both_cnt, 0);

    // Return FIFO back-pressure: credits stop reads at 16.
    do_reset(19'h10, 19'h13);
    write_n(4);
    ticks(2);
    bus.ret_ready = 1'b0;
    bus.rd_req = 1'b1;
    ticks(60);
    check("t4_stall_reads", rd_addr_q.size(), 16);
    check("t4_stall_gnt", bus.rd_gnt, 0);
    check("t4_stall_vld", bus.ret_vld, 1);
    check("t4_no_pop", ret_q.size(), 0);
    bus.ret_ready = 1'b1;
    g = 0;
    while (rd_addr_q.size() < 32 && g < 400) begin tick(); g++; end
    bus.rd_req = 1'b0;
    ticks(30);
    check("t4_resumed", rd_addr_q.size() >= 32, 1);
    check("t4_ret_count", ret_q.size(), rd_addr_q.size());
    for (int i = 0; i < ret_q.size(); i++) check($sformatf("t4_ret%0d", i), ret_q[i], dpat(i % 4));
    check("t4_drained", bus.ret_vld, 0);
    check("t4_rd_err", rd_err, 0);

    // Spurious return with nothing outstanding.
    inj = 1'b1;
    tick();
    inj = 1'b0;
    ticks(3);
    check("t5_rd_err_set", rd_err, 1);
    check("t5_fifo_empty", bus.ret_vld, 0);
    sw_rst = 1'b1;
    ticks(2);
    sw_rst = 1'b0;
    tick();
    check("t5_sw_rst_clear", rd_err, 0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    ticks(3);
    check("t5_blank_rd_err", rd_err, 0);
    check("t5_blank_fifo", bus.ret_vld, 0);

    // Inverted window: nothing is granted.
    do_reset(19'h20, 19'h1F);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    ticks(10);
    check("t6_bad_wr_gnt", bus.wr_gnt, 0);
    check("t6_bad_cmds", wr_addr_q.size() + rd_addr_q.size(), 0);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;

    // Calibration gating and first-command latency.
    do_reset(19'h10, 19'h13);
    calib = 1'b0;
    bus.wr_req = 1'b1;
    ticks(10);
    check("t7_no_cmd", wr_addr_q.size() + rd_addr_q.size(), 0);
    calib = 1'b1;
    tick();
    check("t7_cmd_c1", bus.user_app_wr_cmd, 0);
    tick();
    check("t7_cmd_c2", bus.user_app_wr_cmd, 1);
    check("t7_addr", bus.user_app_wr_addr, 19'h10);
    bus.wr_req = 1'b0;
    ticks(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

endmodule
